pe_relaxa_paralelo: RTL
=======================

Name: pe_relaxa_paralelo

Overview:
- Multi-lane, pipelined edge-relaxation processing element for the shortest-path engine.
- Each beat carries one source-node distance plus NUM_VIZINHOS neighbour (cost, current distance) pairs.
- Per lane it computes candidate = dist_no + custo and flags an update when the candidate is strictly smaller than the neighbour's distance.
- Adds valid/ready streaming with backpressure, saturating infinity-aware arithmetic, lane masking, and a per-node update counter delimited by a last flag.

Parameters:
- DIST_WIDTH, 8, distance width; all-ones value = INF (unreached).
- CUSTO_WIDTH, 8, edge-cost width; must be <= DIST_WIDTH.
- NUM_VIZINHOS, 4, lanes processed per beat.
- CONT_WIDTH, 8, width of per-node update counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- entrada_valida_in  in  1  input beat valid.
- entrada_pronta_out  out  1  block can accept input beat.
- dist_no_in  in  DIST_WIDTH  source-node distance.
- custo_vizinho_in  in  NUM_VIZINHOS*CUSTO_WIDTH  lane i at [i*CUSTO_WIDTH +: CUSTO_WIDTH].
- dist_vizinho_in  in  NUM_VIZINHOS*DIST_WIDTH  lane i at [i*DIST_WIDTH +: DIST_WIDTH].
- mascara_in  in  NUM_VIZINHOS  1 = lane holds a real edge.
- ultimo_in  in  1  last beat of this source node's neighbour list.
- saida_valida_out  out  1  output beat valid.
- saida_pronta_in  in  1  downstream accepts output beat.
- update_out  out  NUM_VIZINHOS  per-lane update flag.
- nova_dist_out  out  NUM_VIZINHOS*DIST_WIDTH  per-lane resulting distance.
- ultimo_out  out  1  ultimo_in carried through the pipeline.
- num_updates_out  out  CONT_WIDTH  updates in the node so far; final total when ultimo_out=1.

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - Clears both stage valids, all output registers, and the counter.
  - Every output reads 0 after reset, except entrada_pronta_out, which reads 1.
  - Reset mid-stream discards all in-flight beats; no partial output.
- Pipeline, two register stages:
  - S1 latches the inputs plus the lane sums.
  - S2 latches the compare results (the outputs).
  - A stage loads when it is empty or its contents leave this cycle.
  - entrada_pronta_out = !v1 | (!v2 | saida_pronta_in). This is combinational and depends on saida_pronta_in only, never on entrada_valida_in.
  - Transfer occurs on valida & pronta. Latency: input handshake at cycle N -> saida_valida_out at N+2 when unstalled.
  - Throughput: 1 beat/cycle.
- Backpressure: while saida_valida_out=1 and saida_pronta_in=0, all S2 outputs hold stable. S1 holds when S2 is full and stalled.
- Arithmetic per lane:
  - custo is zero-extended to DIST_WIDTH+1.
  - sum = dist_no + custo. If dist_no == INF or sum >= INF, candidate = INF; else candidate = sum[DIST_WIDTH-1:0].
- Compare per lane:
  - upd = mascara & (candidate < dist_vizinho), strict.
  - nova_dist = upd ? candidate : dist_vizinho.
  - Masked-off lanes: upd=0, nova_dist = dist_vizinho unchanged.
  - Equal distances: no update. INF candidate never updates.
- Counter:
  - On each S1->S2 load: cnt = (previous loaded beat had ultimo ? 0 : cnt) + popcount(upd).
  - Saturates at 2^CONT_WIDTH-1.
  - num_updates_out = cnt register, held with S2.
  - A single-beat node (ultimo on its first beat) reports only its own popcount.
- Simultaneous input and output handshake in the same cycle with a full pipeline: both transfer, with no bubble.

Decomposition:
- Shared package pe_pkg:
  - INF constant function (all-ones of DIST_WIDTH).
  - Lane slice index helpers.
  - Popcount function.
- One natural sub-module: pe_relaxa_lane. It is the combinational per-lane saturating add + compare + select and is instantiated NUM_VIZINHOS times by a generate loop. Pipeline, handshake, and counter stay in the top module.

Test Plan:
- Single beat, defaults: dist_no=10, custo={1,5,3,200}, dist_vizinho={20,15,13,50}, mascara=4'b1111, ultimo=1, saida_pronta held 1. Expected output 2 cycles later:
  - update={1,0,0,0}.
  - nova_dist={11,15,13,50}.
  - num_updates_out=1.
- Infinity and saturation:
  - dist_no=255 -> all update=0, nova_dist=dist_vizinho.
  - dist_no=250, custo=10, dist_vizinho=255 -> candidate INF, update=0.
  - dist_no=250, custo=4, dist_vizinho=255 -> update=1, nova=254.
- Mask:
  - mascara=4'b0101 with all lanes improvable -> update=4'b0101.
  - Masked lanes pass dist_vizinho unchanged.
- Multi-beat node: three beats with 2, 3, 1 updates, ultimo on the third, then a new node with 4 updates and ultimo=1 -> num_updates_out = 2, 5, 6, then 4.
- Backpressure: stream 5 back-to-back beats while saida_pronta_in=0 for 3 cycles mid-stream.
  - entrada_pronta_out drops once both stages are full.
  - Outputs stay stable while stalled.
  - All 5 beats emerge in order, none lost or duplicated.
- Reset mid-stream: assert rst with both stages valid.
  - Next cycle: saida_valida_out=0, num_updates_out=0, entrada_pronta_out=1.
  - A subsequent node's count starts from 0.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared helpers for the edge-relaxation processing element: INF value,
// lane slice offsets and a popcount used by the update counter.
package pe_pkg;

  localparam int MAX_LANES = 32;

  function automatic logic [63:0] inf_value(input int width);
    return (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
  endfunction

  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

  function automatic logic [7:0] popcount(input logic [MAX_LANES-1:0] bits);
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      n = n + {7'd0, bits[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/pe_relaxa_lane.sv
// One relaxation lane: the saturating add feeds S1, the compare/select
// works on the candidate already latched in S1.
module pe_relaxa_lane
  import pe_pkg::*;
#(
  parameter int DIST_WIDTH  = 8,
  parameter int CUSTO_WIDTH = 8
) (
  input  logic [DIST_WIDTH-1:0]  dist_no,
  input  logic [CUSTO_WIDTH-1:0] custo,
  output logic [DIST_WIDTH-1:0]  candidato,
  input  logic [DIST_WIDTH-1:0]  candidato_reg,
  input  logic [DIST_WIDTH-1:0]  dist_vizinho,
  input  logic                   mascara,
  output logic                   update,
  output logic [DIST_WIDTH-1:0]  nova_dist
);

  localparam logic [DIST_WIDTH-1:0] INF = DIST_WIDTH'(inf_value(DIST_WIDTH));

  logic [DIST_WIDTH:0] soma;

  // An unreached source, or a sum reaching the all-ones code, stays INF.
  always_comb begin
    soma = {1'b0, dist_no} + (DIST_WIDTH+1)'(custo);
    if (dist_no == INF || soma >= {1'b0, INF}) begin
      candidato = INF;
    end else begin
      candidato = soma[DIST_WIDTH-1:0];
    end
  end

  assign update    = mascara && (candidato_reg < dist_vizinho);
  assign nova_dist = update ? candidato_reg : dist_vizinho;

endmodule

// File: rtl/pe_relaxa_paralelo.sv
// Multi-lane pipelined edge relaxation: S1 holds inputs plus lane sums,
// S2 holds compare results and the per-node update count.
module pe_relaxa_paralelo
  import pe_pkg::*;
#(
  parameter int DIST_WIDTH   = 8,
  parameter int CUSTO_WIDTH  = 8,
  parameter int NUM_VIZINHOS = 4,
  parameter int CONT_WIDTH   = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               entrada_valida_in,
  output logic                               entrada_pronta_out,
  input  logic [DIST_WIDTH-1:0]              dist_no_in,
  input  logic [NUM_VIZINHOS*CUSTO_WIDTH-1:0] custo_vizinho_in,
  input  logic [NUM_VIZINHOS*DIST_WIDTH-1:0] dist_vizinho_in,
  input  logic [NUM_VIZINHOS-1:0]            mascara_in,
  input  logic                               ultimo_in,
  output logic                               saida_valida_out,
  input  logic                               saida_pronta_in,
  output logic [NUM_VIZINHOS-1:0]            update_out,
  output logic [NUM_VIZINHOS*DIST_WIDTH-1:0] nova_dist_out,
  output logic                               ultimo_out,
  output logic [CONT_WIDTH-1:0]              num_updates_out
);

  localparam int CSW = CONT_WIDTH + 8;
  localparam logic [CONT_WIDTH-1:0] CONT_MAX = '1;

  logic                               v1, v2;
  logic                               carga_s2;
  logic [NUM_VIZINHOS*DIST_WIDTH-1:0] cand_comb, cand_s1, dist_viz_s1, nova_comb;
  logic [NUM_VIZINHOS-1:0]            mascara_s1, upd_comb;
  logic                               ultimo_s1;
  logic [CONT_WIDTH-1:0]              cont_base, cont_prox;
  logic [CSW-1:0]                     cont_soma;

  assign carga_s2           = !v2 || saida_pronta_in;
  assign entrada_pronta_out = !v1 || carga_s2;
  assign saida_valida_out   = v2;

  for (genvar g = 0; g < NUM_VIZINHOS; g++) begin : g_lane
    pe_relaxa_lane #(
      .DIST_WIDTH (DIST_WIDTH),
      .CUSTO_WIDTH(CUSTO_WIDTH)
    ) u_lane (
      .dist_no      (dist_no_in),
      .custo        (custo_vizinho_in[lane_lo(g, CUSTO_WIDTH) +: CUSTO_WIDTH]),
      .candidato    (cand_comb[lane_lo(g, DIST_WIDTH) +: DIST_WIDTH]),
      .candidato_reg(cand_s1[lane_lo(g, DIST_WIDTH) +: DIST_WIDTH]),
      .dist_vizinho (dist_viz_s1[lane_lo(g, DIST_WIDTH) +: DIST_WIDTH]),
      .mascara      (mascara_s1[g]),
      .update       (upd_comb[g]),
      .nova_dist    (nova_comb[lane_lo(g, DIST_WIDTH) +: DIST_WIDTH])
    );
  end

  // The beat currently in S2 tells whether the next one starts a new node.
  always_comb begin
    cont_base = ultimo_out ? '0 : num_updates_out;
    cont_soma = CSW'(cont_base) + CSW'(popcount(MAX_LANES'(upd_comb)));
    cont_prox = (cont_soma > CSW'(CONT_MAX)) ? CONT_MAX : cont_soma[CONT_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1          <= 1'b0;
      cand_s1     <= '0;
      dist_viz_s1 <= '0;
      mascara_s1  <= '0;
      ultimo_s1   <= 1'b0;
    end else if (entrada_pronta_out) begin
      v1 <= entrada_valida_in;
      if (entrada_valida_in) begin
        cand_s1     <= cand_comb;
        dist_viz_s1 <= dist_vizinho_in;
        mascara_s1  <= mascara_in;
        ultimo_s1   <= ultimo_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v2              <= 1'b0;
      update_out      <= '0;
      nova_dist_out   <= '0;
      ultimo_out      <= 1'b0;
      num_updates_out <= '0;
    end else if (carga_s2) begin
      v2 <= v1;
      if (v1) begin
        update_out      <= upd_comb;
        nova_dist_out   <= nova_comb;
        ultimo_out      <= ultimo_s1;
        num_updates_out <= cont_prox;
      end
    end
  end

endmodule
